// File: rtl/hex_display_mux_wb.sv
// Wishbone-slave seven-segment controller: up to eight hex digits with decimal points,
// leading-zero suppression, blinking, a parallel segment bus and a multiplexed scan bus.
module hex_display_mux_wb #(
   parameter int NDIGITS   = 4,
   parameter int BLINK_DIV = 25000000,
   parameter int SCAN_DIV  = 50000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             wb_adr_i,
   input  logic [15:0]            wb_dat_i,
   output logic [15:0]            wb_dat_o,
   input  logic [1:0]             wb_sel_i,
   input  logic                   wb_we_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   output logic                   wb_ack_o,
   output logic [8*NDIGITS-1:0]   seg_o,
   output logic [NDIGITS-1:0]     scan_o,
   output logic [7:0]             mux_seg_o
);

   localparam int BW = $clog2(BLINK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   localparam logic [63:0] VAL_MASK64 = (64'd1 << (4 * NDIGITS)) - 64'd1;
   localparam logic [31:0] VAL_MASK   = VAL_MASK64[31:0];
   localparam logic [15:0] DP_MASK16  = (16'd1 << NDIGITS) - 16'd1;
   localparam logic [7:0]  DP_MASK    = DP_MASK16[7:0];

   function automatic logic [7:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 8'hC0;
         4'h1: glyph = 8'hF9;
         4'h2: glyph = 8'hA4;
         4'h3: glyph = 8'hB0;
         4'h4: glyph = 8'h99;
         4'h5: glyph = 8'h92;
         4'h6: glyph = 8'h82;
         4'h7: glyph = 8'hF8;
         4'h8: glyph = 8'h80;
         4'h9: glyph = 8'h90;
         4'hA: glyph = 8'h88;
         4'hB: glyph = 8'h83;
         4'hC: glyph = 8'hC6;
         4'hD: glyph = 8'hA1;
         4'hE: glyph = 8'h86;
         default: glyph = 8'h8E;
      endcase
   endfunction

   logic [31:0]   value_r;
   logic [7:0]    dp_r;
   logic [2:0]    ctrl_r;
   logic          acc;
   logic [15:0]   wmask;
   logic [15:0]   rd_data;

   assign acc   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wmask = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

   always_comb begin
      rd_data = '0;
      case (wb_adr_i)
         2'd0:    rd_data = value_r[15:0];
         2'd1:    rd_data = value_r[31:16];
         2'd2:    rd_data = {8'h00, dp_r};
         default: rd_data = {13'h0, ctrl_r};
      endcase
   end

   // Bus stage: register file, ack and read data share one registered cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         value_r  <= '0;
         dp_r     <= '0;
         ctrl_r   <= 3'b001;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= acc;
         if (acc) begin
            wb_dat_o <= rd_data;
            if (wb_we_i) begin
               case (wb_adr_i)
                  2'd0: value_r[15:0]  <= (value_r[15:0] & ~wmask) |
                                          (wb_dat_i & wmask & VAL_MASK[15:0]);
                  2'd1: value_r[31:16] <= (value_r[31:16] & ~wmask) |
                                          (wb_dat_i & wmask & VAL_MASK[31:16]);
                  2'd2: if (wb_sel_i[0]) dp_r <= wb_dat_i[7:0] & DP_MASK;
                  default: if (wb_sel_i[0]) ctrl_r <= wb_dat_i[2:0];
               endcase
            end
         end
      end
   end

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [SW-1:0] scan_cnt;
   logic [IW-1:0] scan_idx;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         scan_cnt    <= '0;
         scan_idx    <= '0;
      end else begin
         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IW'(NDIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

   logic [7:0]           dig_p0 [NDIGITS];
   logic [8*NDIGITS-1:0] seg_p0;
   logic [3:0]           nib;
   logic                 upper_zero;
   logic                 blank;

   // Pattern stage: walk from the top digit down so LZS sees "this digit and all above are 0"
   always_comb begin
      seg_p0     = '0;
      nib        = '0;
      upper_zero = 1'b1;
      blank      = 1'b0;
      for (int k = NDIGITS - 1; k >= 0; k--) begin
         nib        = value_r[4*k +: 4];
         upper_zero = upper_zero & (nib == 4'h0);
         blank      = ~ctrl_r[0] | (ctrl_r[1] & blink_phase) |
                      (ctrl_r[2] & upper_zero & (k != 0));
         dig_p0[k]  = blank ? 8'hFF : (glyph(nib) & ~{dp_r[k], 7'b0});
         seg_p0[8*k +: 8] = dig_p0[k];
      end
   end

   logic [8*NDIGITS-1:0] seg_p1;
   logic [NDIGITS-1:0]   scan_p1;
   logic [7:0]           mux_p1;

   // Output stage: every display output is registered from the same scan index
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seg_p1  <= {NDIGITS{8'hC0}};
         scan_p1 <= ~NDIGITS'(1);
         mux_p1  <= 8'hC0;
      end else begin
         seg_p1  <= seg_p0;
         scan_p1 <= ~(NDIGITS'(1) << scan_idx);
         mux_p1  <= dig_p0[scan_idx];
      end
   end

   assign seg_o     = seg_p1;
   assign scan_o    = scan_p1;
   assign mux_seg_o = mux_p1;

endmodule

// File: tb/tb_hex_display_mux_wb.sv
// Directed bench for hex_display_mux_wb: a 4-digit instance with fast blink/scan and a
// 3-digit instance for scan sequencing and digit masking.
module tb_hex_display_mux_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  adr = '0;
   logic [15:0] dat = '0;
   logic [1:0]  sel = '0;
   logic        we  = 1'b0;
   logic        cyc_a = 1'b0, stb_a = 1'b0, cyc_b = 1'b0, stb_b = 1'b0;
   logic [15:0] dat_a, dat_b;
   logic        ack_a, ack_b;
   logic [31:0] seg_a;
   logic [3:0]  scan_a;
   logic [7:0]  mux_a;
   logic [23:0] seg_b;
   logic [2:0]  scan_b;
   logic [7:0]  mux_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hex_display_mux_wb #(.NDIGITS(4), .BLINK_DIV(4), .SCAN_DIV(3)) dut_a (
      .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_a),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb_a), .wb_ack_o(ack_a),
      .seg_o(seg_a), .scan_o(scan_a), .mux_seg_o(mux_a));

   hex_display_mux_wb #(.NDIGITS(3), .BLINK_DIV(100), .SCAN_DIV(3)) dut_b (
      .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_b),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb_b), .wb_ack_o(ack_b),
      .seg_o(seg_b), .scan_o(scan_b), .mux_seg_o(mux_b));

   task automatic wb_access(input bit b, input bit w, input logic [1:0] a,
                            input logic [15:0] d, input logic [1:0] s,
                            output logic [15:0] q);
      bit got;
      adr = a; dat = d; sel = s; we = w;
      if (b) begin cyc_b = 1'b1; stb_b = 1'b1; end
      else   begin cyc_a = 1'b1; stb_a = 1'b1; end
      got = 1'b0;
      q   = '0;
      for (int t = 0; t < 8 && !got; t++) begin
         @(posedge clk); #1;
         if ((b ? ack_b : ack_a) === 1'b1) begin
            got = 1'b1;
            q   = b ? dat_b : dat_a;
         end
      end
      cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0; we = 1'b0;
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL ack_timeout: got no ack, required ack within 8 cycles (adr %0d)", a);
      end
      @(posedge clk); #1;
      n_checks++;
      if ((b ? ack_b : ack_a) !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_pulse: got ack=%b after strobe dropped, required 0", b ? ack_b : ack_a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (seg_a !== 32'hC0C0C0C0) begin n_fail++; $display("FAIL reset_seg: got %h required c0c0c0c0", seg_a); end
      n_checks++;
      if (scan_a !== 4'b1110) begin n_fail++; $display("FAIL reset_scan: got %b required 1110", scan_a); end
      n_checks++;
      if (mux_a !== 8'hC0) begin n_fail++; $display("FAIL reset_mux: got %h required c0", mux_a); end
      n_checks++;
      if (ack_a !== 1'b0 || dat_a !== 16'h0000) begin
         n_fail++; $display("FAIL reset_bus: got ack=%b dat=%h required ack=0 dat=0000", ack_a, dat_a);
      end
      n_checks++;
      if (scan_b !== 3'b110 || seg_b !== 24'hC0C0C0) begin
         n_fail++; $display("FAIL reset_b: got scan=%b seg=%h required 110 c0c0c0", scan_b, seg_b);
      end
      // CTRL read with strobe held: ack must be a single-cycle pulse
      adr = 2'd3; we = 1'b0; sel = 2'b11; cyc_a = 1'b1; stb_a = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (ack_a !== 1'b1 || dat_a !== 16'h0001) begin
         n_fail++; $display("FAIL reset_ctrl: got ack=%b dat=%h required ack=1 dat=0001", ack_a, dat_a);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ack_a !== 1'b0) begin n_fail++; $display("FAIL held_stb_ack: got %b required 0", ack_a); end
      cyc_a = 1'b0; stb_a = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_value();
      logic [15:0] q;
      wb_access(0, 1, 2'd0, 16'h12AF, 2'b11, q);
      n_checks++;
      if (seg_a !== 32'hF9A4888E) begin n_fail++; $display("FAIL value_full: got %h required f9a4888e", seg_a); end
      wb_access(0, 1, 2'd0, 16'h3400, 2'b10, q);
      n_checks++;
      if (seg_a !== 32'hB099888E) begin n_fail++; $display("FAIL value_lane: got %h required b099888e", seg_a); end
      wb_access(0, 0, 2'd0, 16'h0000, 2'b11, q);
      n_checks++;
      if (q !== 16'h34AF) begin n_fail++; $display("FAIL value_read: got %h required 34af", q); end
   endtask

   task automatic test_lzs();
      logic [15:0] q;
      wb_access(0, 1, 2'd0, 16'h0005, 2'b11, q);
      wb_access(0, 1, 2'd3, 16'h0005, 2'b11, q);
      n_checks++;
      if (seg_a !== 32'hFFFFFF92) begin n_fail++; $display("FAIL lzs_5: got %h required ffffff92", seg_a); end
      wb_access(0, 1, 2'd0, 16'h0000, 2'b11, q);
      n_checks++;
      if (seg_a !== 32'hFFFFFFC0) begin n_fail++; $display("FAIL lzs_0: got %h required ffffffc0", seg_a); end
      wb_access(0, 1, 2'd2, 16'h0002, 2'b11, q);
      n_checks++;
      if (seg_a !== 32'hFFFFFFC0) begin n_fail++; $display("FAIL lzs_dp_blank: got %h required ffffffc0", seg_a); end
      wb_access(0, 1, 2'd2, 16'h0001, 2'b11, q);
      n_checks++;
      if (seg_a !== 32'hFFFFFF40) begin n_fail++; $display("FAIL lzs_dp0: got %h required ffffff40", seg_a); end
      wb_access(0, 1, 2'd2, 16'h0000, 2'b11, q);
      wb_access(0, 1, 2'd0, 16'h0105, 2'b11, q);
      n_checks++;
      if (seg_a !== 32'hFFF9C092) begin n_fail++; $display("FAIL lzs_inner_zero: got %h required fff9c092", seg_a); end
   endtask

   task automatic test_blink();
      logic [15:0] q;
      logic [31:0] prev;
      int run, trans;
      wb_access(0, 1, 2'd0, 16'h12AF, 2'b11, q);
      wb_access(0, 1, 2'd3, 16'h0003, 2'b11, q);
      prev = seg_a; run = 0; trans = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (seg_a !== 32'hF9A4888E && seg_a !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL blink_pattern: got %h required f9a4888e or ffffffff", seg_a);
         end
         if (seg_a !== prev) begin
            if (trans > 0) begin
               n_checks++;
               if (run != 4) begin n_fail++; $display("FAIL blink_period: got run %0d required 4", run); end
            end
            trans++; run = 1; prev = seg_a;
         end else begin
            run++;
         end
      end
      n_checks++;
      if (trans < 3) begin n_fail++; $display("FAIL blink_toggles: got %0d transitions required >= 3", trans); end
      wb_access(0, 1, 2'd3, 16'h0000, 2'b11, q);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (seg_a !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL disabled: got %h required ffffffff", seg_a); end
      end
   endtask

   task automatic test_scan();
      logic [15:0] q;
      logic [2:0]  prev;
      logic [7:0]  exp_mux;
      int run, trans;
      wb_access(1, 1, 2'd0, 16'h0123, 2'b11, q);
      n_checks++;
      if (seg_b !== 24'hF9A4B0) begin n_fail++; $display("FAIL scan_seg: got %h required f9a4b0", seg_b); end
      prev = scan_b; run = 0; trans = 0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         case (scan_b)
            3'b110:  exp_mux = 8'hB0;
            3'b101:  exp_mux = 8'hA4;
            3'b011:  exp_mux = 8'hF9;
            default: exp_mux = 8'hxx;
         endcase
         n_checks++;
         if (exp_mux === 8'hxx || mux_b !== exp_mux) begin
            n_fail++; $display("FAIL scan_mux: got scan=%b mux=%h required mux=%h", scan_b, mux_b, exp_mux);
         end
         if (scan_b !== prev) begin
            n_checks++;
            if (scan_b !== {prev[1:0], prev[2]}) begin
               n_fail++; $display("FAIL scan_order: got %b after %b required %b", scan_b, prev, {prev[1:0], prev[2]});
            end
            if (trans > 0) begin
               n_checks++;
               if (run != 3) begin n_fail++; $display("FAIL scan_period: got run %0d required 3", run); end
            end
            trans++; run = 1; prev = scan_b;
         end else begin
            run++;
         end
      end
      n_checks++;
      if (trans < 6) begin n_fail++; $display("FAIL scan_steps: got %0d steps required >= 6", trans); end
   endtask

   task automatic test_masks();
      logic [15:0] q;
      wb_access(0, 1, 2'd1, 16'hFFFF, 2'b11, q);
      wb_access(0, 0, 2'd1, 16'h0000, 2'b11, q);
      n_checks++;
      if (q !== 16'h0000) begin n_fail++; $display("FAIL mask_hi: got %h required 0000", q); end
      wb_access(0, 1, 2'd2, 16'hFFFF, 2'b11, q);
      wb_access(0, 0, 2'd2, 16'h0000, 2'b11, q);
      n_checks++;
      if (q !== 16'h000F) begin n_fail++; $display("FAIL mask_dp: got %h required 000f", q); end
      wb_access(1, 1, 2'd0, 16'hFFFF, 2'b11, q);
      wb_access(1, 0, 2'd0, 16'h0000, 2'b11, q);
      n_checks++;
      if (q !== 16'h0FFF) begin n_fail++; $display("FAIL mask_lo_b: got %h required 0fff", q); end
      wb_access(1, 1, 2'd2, 16'h00FF, 2'b11, q);
      wb_access(1, 0, 2'd2, 16'h0000, 2'b11, q);
      n_checks++;
      if (q !== 16'h0007) begin n_fail++; $display("FAIL mask_dp_b: got %h required 0007", q); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] q;
      adr = 2'd0; dat = 16'h5555; sel = 2'b11; we = 1'b1;
      cyc_a = 1'b1; stb_a = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ack: got %b required 0", ack_a); end
      cyc_a = 1'b0; stb_a = 1'b0; we = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      wb_access(0, 0, 2'd0, 16'h0000, 2'b11, q);
      n_checks++;
      if (q !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_value: got %h required 0000", q); end
      wb_access(0, 0, 2'd3, 16'h0000, 2'b11, q);
      n_checks++;
      if (q !== 16'h0001) begin n_fail++; $display("FAIL reset_mid_ctrl: got %h required 0001", q); end
      n_checks++;
      if (seg_a !== 32'hC0C0C0C0) begin n_fail++; $display("FAIL reset_mid_seg: got %h required c0c0c0c0", seg_a); end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_value();
      test_lzs();
      test_blink();
      test_scan();
      test_masks();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
